// File: rtl/pipe_hazard_ctrl_if.sv
// Latch enable/flush bundle driven by the hazard controller into the pipeline latches and PC.
interface pipe_hazard_ctrl_if;
  logic PC_EN;
  logic IF_ID_EN;
  logic IF_ID_flush;
  logic ID_EX_EN;
  logic ID_EX_flush;
  logic EX_MEM_EN;
  logic EX_MEM_flush;

  modport master (
    output PC_EN, IF_ID_EN, IF_ID_flush, ID_EX_EN, ID_EX_flush, EX_MEM_EN, EX_MEM_flush
  );

  modport slave (
    input PC_EN, IF_ID_EN, IF_ID_flush, ID_EX_EN, ID_EX_flush, EX_MEM_EN, EX_MEM_flush
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: load-use bubbles, branch/trap flushes, memory-wait freeze,
// ALU operand forwarding and a saturating stall counter.
module pipe_hazard_ctrl #(
  parameter int unsigned TRAP_CYCLES = 2,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       rs1_ID,
  input  logic [4:0]       rs2_ID,
  input  logic             rs1_use_ID,
  input  logic             rs2_use_ID,
  input  logic [4:0]       rs1_EX,
  input  logic [4:0]       rs2_EX,
  input  logic [4:0]       rd_EX,
  input  logic             RegWrite_EX,
  input  logic             mem_r_EX,
  input  logic [4:0]       rd_MEM,
  input  logic             RegWrite_MEM,
  input  logic [4:0]       rd_WB,
  input  logic             RegWrite_WB,
  input  logic             br_taken_EX,
  input  logic             trap_EX,
  input  logic             mret_EX,
  input  logic             mem_req_MEM,
  input  logic             mem_ack,
  input  logic             stall_cnt_clr,
  pipe_hazard_ctrl_if.master latch,
  output logic [1:0]       fwd_A,
  output logic [1:0]       fwd_B,
  output logic             trap_busy,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic [1:0] {StRun, StMemWait, StTrapFlush} state_e;

  localparam logic [2:0] TcntLoad = 3'(TRAP_CYCLES - 1);

  state_e           state_q, state_d;
  logic [2:0]       tcnt_q, tcnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic freeze, redirect, load_use;
  logic pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en, ex_mem_flush;

  assign freeze   = mem_req_MEM & ~mem_ack;
  assign redirect = trap_EX | mret_EX;
  assign load_use = mem_r_EX & RegWrite_EX & (rd_EX != 5'd0) &
                    ((rs1_use_ID & (rs1_ID == rd_EX)) | (rs2_use_ID & (rs2_ID == rd_EX)));

  always_comb begin
    state_d      = state_q;
    tcnt_d       = tcnt_q;
    pc_en        = 1'b1;
    if_id_en     = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_en     = 1'b1;
    id_ex_flush  = 1'b0;
    ex_mem_en    = 1'b1;
    ex_mem_flush = 1'b0;

    if (freeze) begin
      pc_en     = 1'b0;
      if_id_en  = 1'b0;
      id_ex_en  = 1'b0;
      ex_mem_en = 1'b0;
      // A freeze during the trap window just parks tcnt; it does not leave TRAP_FLUSH.
      if (state_q != StTrapFlush) begin
        state_d = StMemWait;
      end
    end else if (state_q == StTrapFlush) begin
      if_id_flush  = 1'b1;
      id_ex_flush  = 1'b1;
      ex_mem_flush = 1'b1;
      if (tcnt_q <= 3'd1) begin
        state_d = StRun;
        tcnt_d  = 3'd0;
      end else begin
        tcnt_d = tcnt_q - 3'd1;
      end
    end else if (redirect) begin
      if_id_flush  = 1'b1;
      id_ex_flush  = 1'b1;
      ex_mem_flush = 1'b1;
      tcnt_d       = TcntLoad;
      state_d      = (TRAP_CYCLES > 1) ? StTrapFlush : StRun;
    end else begin
      // Covers both RUN and the ack cycle that ends MEM_WAIT.
      state_d = StRun;
      if (br_taken_EX) begin
        if_id_flush = 1'b1;
        id_ex_flush = 1'b1;
      end else if (load_use) begin
        pc_en       = 1'b0;
        if_id_en    = 1'b0;
        id_ex_flush = 1'b1;
      end
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall_cnt_clr) begin
      stall_cnt_d = '0;
    end else if (!pc_en && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StRun;
      tcnt_q      <= 3'd0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      tcnt_q      <= tcnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  function automatic logic [1:0] fwd_sel(input logic [4:0] rs);
    if (RegWrite_MEM && (rd_MEM != 5'd0) && (rd_MEM == rs)) begin
      return 2'b01;
    end else if (RegWrite_WB && (rd_WB != 5'd0) && (rd_WB == rs)) begin
      return 2'b10;
    end
    return 2'b00;
  endfunction

  assign fwd_A = fwd_sel(rs1_EX);
  assign fwd_B = fwd_sel(rs2_EX);

  assign latch.PC_EN        = pc_en;
  assign latch.IF_ID_EN     = if_id_en;
  assign latch.IF_ID_flush  = if_id_flush;
  assign latch.ID_EX_EN     = id_ex_en;
  assign latch.ID_EX_flush  = id_ex_flush;
  assign latch.EX_MEM_EN    = ex_mem_en;
  assign latch.EX_MEM_flush = ex_mem_flush;

  assign trap_busy = (state_q == StTrapFlush);
  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: vector table, hand-written multi-cycle sequences and a
// randomized run against a remaining-flush-cycles reference model.
module tb_pipe_hazard_ctrl;
  localparam int unsigned TC    = 2;
  localparam int unsigned CW    = 4;
  localparam int          SMAX  = (1 << CW) - 1;

  // Control word: {PC_EN, IF_ID_EN, IF_ID_flush, ID_EX_EN, ID_EX_flush, EX_MEM_EN,
  //                EX_MEM_flush, trap_busy}
  localparam logic [7:0] NRM   = 8'b1101_0100;
  localparam logic [7:0] FRZ   = 8'b0000_0000;
  localparam logic [7:0] FRZ_T = 8'b0000_0001;
  localparam logic [7:0] RDR   = 8'b1111_1110;
  localparam logic [7:0] TFL   = 8'b1111_1111;
  localparam logic [7:0] BRF   = 8'b1111_1100;
  localparam logic [7:0] LUS   = 8'b0001_1100;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [4:0] rs1_ID, rs2_ID, rs1_EX, rs2_EX, rd_EX, rd_MEM, rd_WB;
  logic rs1_use_ID, rs2_use_ID, RegWrite_EX, mem_r_EX, RegWrite_MEM, RegWrite_WB;
  logic br_taken_EX, trap_EX, mret_EX, mem_req_MEM, mem_ack, stall_cnt_clr;
  logic [1:0] fwd_A, fwd_B;
  logic trap_busy;
  logic [CW-1:0] stall_cnt;
  logic [7:0] ctl;

  int checks = 0;
  int errors = 0;

  pipe_hazard_ctrl_if lif ();

  pipe_hazard_ctrl #(.TRAP_CYCLES(TC), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .rs1_ID(rs1_ID), .rs2_ID(rs2_ID), .rs1_use_ID(rs1_use_ID), .rs2_use_ID(rs2_use_ID),
    .rs1_EX(rs1_EX), .rs2_EX(rs2_EX), .rd_EX(rd_EX), .RegWrite_EX(RegWrite_EX),
    .mem_r_EX(mem_r_EX), .rd_MEM(rd_MEM), .RegWrite_MEM(RegWrite_MEM), .rd_WB(rd_WB),
    .RegWrite_WB(RegWrite_WB), .br_taken_EX(br_taken_EX), .trap_EX(trap_EX),
    .mret_EX(mret_EX), .mem_req_MEM(mem_req_MEM), .mem_ack(mem_ack),
    .stall_cnt_clr(stall_cnt_clr), .latch(lif), .fwd_A(fwd_A), .fwd_B(fwd_B),
    .trap_busy(trap_busy), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  assign ctl = {lif.PC_EN, lif.IF_ID_EN, lif.IF_ID_flush, lif.ID_EX_EN, lif.ID_EX_flush,
                lif.EX_MEM_EN, lif.EX_MEM_flush, trap_busy};

  typedef struct packed {
    logic [4:0] rs1_id; logic [4:0] rs2_id; logic rs1_use; logic rs2_use;
    logic [4:0] rs1_ex; logic [4:0] rs2_ex; logic [4:0] rd_ex; logic rw_ex; logic mem_r;
    logic [4:0] rd_mem; logic rw_mem; logic [4:0] rd_wb; logic rw_wb;
    logic br; logic trap; logic mret; logic req; logic ack;
    logic [7:0] ctl; logic [1:0] fa; logic [1:0] fb;
  } vec_t;

  vec_t vecs [18];

  // Reference model state
  int flush_left;
  int mcnt;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    {rs1_ID, rs2_ID, rs1_EX, rs2_EX, rd_EX, rd_MEM, rd_WB} = '0;
    {rs1_use_ID, rs2_use_ID, RegWrite_EX, mem_r_EX, RegWrite_MEM, RegWrite_WB} = '0;
    {br_taken_EX, trap_EX, mret_EX, mem_req_MEM, mem_ack, stall_cnt_clr} = '0;
  endtask

  task automatic apply(input vec_t v);
    rs1_ID = v.rs1_id; rs2_ID = v.rs2_id; rs1_use_ID = v.rs1_use; rs2_use_ID = v.rs2_use;
    rs1_EX = v.rs1_ex; rs2_EX = v.rs2_ex; rd_EX = v.rd_ex; RegWrite_EX = v.rw_ex;
    mem_r_EX = v.mem_r; rd_MEM = v.rd_mem; RegWrite_MEM = v.rw_mem; rd_WB = v.rd_wb;
    RegWrite_WB = v.rw_wb; br_taken_EX = v.br; trap_EX = v.trap; mret_EX = v.mret;
    mem_req_MEM = v.req; mem_ack = v.ack; stall_cnt_clr = 1'b0;
  endtask

  // Inputs already driven; check before the edge, then advance one cycle.
  task automatic step_chk(input string nm, input logic [7:0] ectl, input int ecnt);
    #2;
    chk({nm, ".ctl"}, 32'(ctl), 32'(ectl));
    chk({nm, ".cnt"}, 32'(stall_cnt), 32'(ecnt));
    tick();
  endtask

  task automatic pulse_reset();
    rst = 1'b0;
    #1;
    rst = 1'b1;
  endtask

  function automatic logic [1:0] ref_fwd(input logic [4:0] rs);
    if (RegWrite_MEM && rd_MEM != 0 && rd_MEM == rs) return 2'b01;
    if (RegWrite_WB && rd_WB != 0 && rd_WB == rs) return 2'b10;
    return 2'b00;
  endfunction

  function automatic logic [7:0] ref_ctl();
    logic lu;
    lu = mem_r_EX && RegWrite_EX && rd_EX != 0 &&
         ((rs1_use_ID && rs1_ID == rd_EX) || (rs2_use_ID && rs2_ID == rd_EX));
    if (mem_req_MEM && !mem_ack) return (flush_left > 0) ? FRZ_T : FRZ;
    if (flush_left > 0)          return TFL;
    if (trap_EX || mret_EX)      return RDR;
    if (br_taken_EX)             return BRF;
    if (lu)                      return LUS;
    return NRM;
  endfunction

  task automatic ref_commit(input logic [7:0] ectl);
    if (!(mem_req_MEM && !mem_ack)) begin
      if (flush_left > 0) flush_left--;
      else if (trap_EX || mret_EX) flush_left = TC - 1;
    end
    if (stall_cnt_clr) mcnt = 0;
    else if (!ectl[7] && mcnt < SMAX) mcnt++;
  endtask

  initial begin
    logic [7:0] ectl;

    vecs[0]  = '{default: '0, ctl: NRM};
    vecs[1]  = '{default: '0, mem_r: 1'b1, rw_ex: 1'b1, rd_ex: 5'd5, rs2_id: 5'd5,
                 rs2_use: 1'b1, ctl: LUS};
    vecs[2]  = '{default: '0, mem_r: 1'b1, rw_ex: 1'b1, rd_ex: 5'd0, rs2_id: 5'd0,
                 rs2_use: 1'b1, ctl: NRM};
    vecs[3]  = '{default: '0, mem_r: 1'b1, rw_ex: 1'b1, rd_ex: 5'd9, rs1_id: 5'd9,
                 rs1_use: 1'b0, ctl: NRM};
    vecs[4]  = '{default: '0, mem_r: 1'b1, rw_ex: 1'b1, rd_ex: 5'd9, rs1_id: 5'd9,
                 rs1_use: 1'b1, ctl: LUS};
    vecs[5]  = '{default: '0, mem_r: 1'b0, rw_ex: 1'b1, rd_ex: 5'd9, rs1_id: 5'd9,
                 rs1_use: 1'b1, ctl: NRM};
    vecs[6]  = '{default: '0, br: 1'b1, ctl: BRF};
    vecs[7]  = '{default: '0, trap: 1'b1, ctl: RDR};
    vecs[8]  = '{default: '0, mret: 1'b1, ctl: RDR};
    vecs[9]  = '{default: '0, trap: 1'b1, br: 1'b1, mem_r: 1'b1, rw_ex: 1'b1, rd_ex: 5'd3,
                 rs1_id: 5'd3, rs1_use: 1'b1, ctl: RDR};
    vecs[10] = '{default: '0, req: 1'b1, ack: 1'b0, trap: 1'b1, ctl: FRZ};
    vecs[11] = '{default: '0, req: 1'b1, ack: 1'b1, br: 1'b1, ctl: BRF};
    vecs[12] = '{default: '0, rs1_ex: 5'd7, rd_mem: 5'd7, rw_mem: 1'b1, rd_wb: 5'd7,
                 rw_wb: 1'b1, ctl: NRM, fa: 2'b01};
    vecs[13] = '{default: '0, rs1_ex: 5'd7, rd_mem: 5'd7, rw_mem: 1'b0, rd_wb: 5'd7,
                 rw_wb: 1'b1, ctl: NRM, fa: 2'b10};
    vecs[14] = '{default: '0, rs2_ex: 5'd0, rd_mem: 5'd0, rw_mem: 1'b1, rd_wb: 5'd0,
                 rw_wb: 1'b1, ctl: NRM, fb: 2'b00};
    vecs[15] = '{default: '0, rs2_ex: 5'd3, rd_mem: 5'd3, rw_mem: 1'b0, rd_wb: 5'd3,
                 rw_wb: 1'b1, ctl: NRM, fb: 2'b10};
    vecs[16] = '{default: '0, rs1_ex: 5'd4, rs2_ex: 5'd4, rd_mem: 5'd4, rw_mem: 1'b1,
                 rd_wb: 5'd6, rw_wb: 1'b1, ctl: NRM, fa: 2'b01, fb: 2'b01};
    vecs[17] = '{default: '0, br: 1'b1, mem_r: 1'b1, rw_ex: 1'b1, rd_ex: 5'd2,
                 rs2_id: 5'd2, rs2_use: 1'b1, ctl: BRF};

    // Reset state with all inputs low
    idle();
    #2;
    chk("reset.ctl", 32'(ctl), 32'(NRM));
    chk("reset.fwd", 32'({fwd_A, fwd_B}), 32'(0));
    chk("reset.cnt", 32'(stall_cnt), 32'(0));
    #10;
    rst = 1'b1;
    tick();

    // Single-cycle vectors from a fresh reset each time
    for (int i = 0; i < 18; i++) begin
      pulse_reset();
      apply(vecs[i]);
      #2;
      chk($sformatf("vec%0d.ctl", i), 32'(ctl), 32'(vecs[i].ctl));
      chk($sformatf("vec%0d.fwd", i), 32'({fwd_A, fwd_B}), 32'({vecs[i].fa, vecs[i].fb}));
      tick();
    end

    // Load-use: one bubble, then the bubble clears rd_EX
    idle();
    pulse_reset();
    mem_r_EX = 1; RegWrite_EX = 1; rd_EX = 5; rs2_ID = 5; rs2_use_ID = 1;
    step_chk("lu_c1", LUS, 0);
    mem_r_EX = 0; RegWrite_EX = 0; rd_EX = 0;
    step_chk("lu_c2", NRM, 1);
    mem_r_EX = 1; RegWrite_EX = 1; rd_EX = 0; rs2_ID = 0;
    step_chk("lu_x0", NRM, 1);
    idle();

    // Trap: two-cycle flush window, branch ignored in second cycle
    trap_EX = 1;
    step_chk("trap_c1", RDR, 1);
    trap_EX = 0; br_taken_EX = 1;
    step_chk("trap_c2", TFL, 1);
    br_taken_EX = 0;
    step_chk("trap_c3", NRM, 1);

    // Freeze with a pending trap, serviced on the ack cycle
    mem_req_MEM = 1; mem_ack = 0; trap_EX = 1;
    step_chk("frz_c1", FRZ, 1);
    step_chk("frz_c2", FRZ, 2);
    step_chk("frz_c3", FRZ, 3);
    mem_ack = 1;
    step_chk("frz_ack", RDR, 4);
    idle();
    step_chk("frz_tfl", TFL, 4);
    step_chk("frz_done", NRM, 4);

    // Freeze inside the trap window holds the window open
    trap_EX = 1;
    step_chk("tf_c1", RDR, 4);
    trap_EX = 0; mem_req_MEM = 1;
    step_chk("tf_frz1", FRZ_T, 4);
    step_chk("tf_frz2", FRZ_T, 5);
    mem_req_MEM = 0;
    step_chk("tf_c2", TFL, 6);
    step_chk("tf_done", NRM, 6);

    // Asynchronous reset in the middle of the trap window
    trap_EX = 1;
    step_chk("rtf_c1", RDR, 6);
    trap_EX = 0;
    chk("rtf_busy", 32'(trap_busy), 32'(1));
    rst = 1'b0;
    #1;
    chk("rtf_rst_busy", 32'(trap_busy), 32'(0));
    chk("rtf_rst_cnt", 32'(stall_cnt), 32'(0));
    #2;
    rst = 1'b1;
    tick();
    step_chk("rtf_after", NRM, 0);

    // Saturation and clear priority
    mem_req_MEM = 1;
    for (int i = 0; i < SMAX + 2; i++) begin
      step_chk($sformatf("sat%0d", i), FRZ, (i < SMAX) ? i : SMAX);
    end
    stall_cnt_clr = 1;
    step_chk("sat_clr", FRZ, SMAX);
    idle();
    step_chk("sat_zero", NRM, 0);

    // Randomized run against the reference model
    pulse_reset();
    flush_left = 0;
    mcnt = 0;
    for (int i = 0; i < 600; i++) begin
      rs1_ID = 5'($urandom_range(0, 3)); rs2_ID = 5'($urandom_range(0, 3));
      rs1_EX = 5'($urandom_range(0, 3)); rs2_EX = 5'($urandom_range(0, 3));
      rd_EX = 5'($urandom_range(0, 3)); rd_MEM = 5'($urandom_range(0, 3));
      rd_WB = 5'($urandom_range(0, 3));
      rs1_use_ID = 1'($urandom); rs2_use_ID = 1'($urandom);
      RegWrite_EX = 1'($urandom); mem_r_EX = 1'($urandom);
      RegWrite_MEM = 1'($urandom); RegWrite_WB = 1'($urandom);
      br_taken_EX = ($urandom_range(0, 7) == 0);
      trap_EX = ($urandom_range(0, 15) == 0);
      mret_EX = ($urandom_range(0, 31) == 0);
      mem_req_MEM = ($urandom_range(0, 3) == 0);
      mem_ack = 1'($urandom);
      stall_cnt_clr = ($urandom_range(0, 63) == 0);
      #2;
      ectl = ref_ctl();
      chk($sformatf("rnd%0d.ctl", i), 32'(ctl), 32'(ectl));
      chk($sformatf("rnd%0d.fwd", i), 32'({fwd_A, fwd_B}),
          32'({ref_fwd(rs1_EX), ref_fwd(rs2_EX)}));
      chk($sformatf("rnd%0d.cnt", i), 32'(stall_cnt), 32'(mcnt));
      ref_commit(ectl);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
